// File: rtl/booth_r4_mult.sv
// Radix-4 Booth sequential multiplier, signed or unsigned per request.
// One add step and one 2-bit shift step per multiplier digit pair.
module booth_r4_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int W  = WIDTH + 2;
    localparam int AW = W + 2;
    localparam int I  = W / 2;
    localparam int CW = $clog2(I);
    localparam logic [CW-1:0] LAST = CW'(I - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_cfg
        $error("booth_r4_mult: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      a_q, a_d;
    logic [AW-1:0]      mx_q, mx_d;
    logic [W-1:0]       q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic               m_sgn, q_sgn;
    logic [AW-1:0]      mx2;

    // Sign source for operand extension; zero in unsigned mode
    assign m_sgn = signed_mode & multiplicand[WIDTH-1];
    assign q_sgn = signed_mode & multiplier[WIDTH-1];
    assign mx2   = {mx_q[AW-2:0], 1'b0};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ADD;
            S_ADD:   state_d = S_SHIFT;
            S_SHIFT: state_d = (cnt_q == LAST) ? S_DONE : S_ADD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state register
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Datapath next-state: capture, Booth add, arithmetic shift
    always_comb begin
        a_d    = a_q;
        mx_d   = mx_q;
        q_d    = q_q;
        qm1_d  = qm1_q;
        cnt_d  = cnt_q;
        prod_d = prod_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = '0;
                    qm1_d = 1'b0;
                    cnt_d = '0;
                    mx_d  = {{(AW - WIDTH){m_sgn}}, multiplicand};
                    q_d   = {{(W - WIDTH){q_sgn}}, multiplier};
                end
            end
            S_ADD: begin
                case ({q_q[1:0], qm1_q})
                    3'b001, 3'b010: a_d = a_q + mx_q;
                    3'b011:         a_d = a_q + mx2;
                    3'b100:         a_d = a_q - mx2;
                    3'b101, 3'b110: a_d = a_q - mx_q;
                    default:        a_d = a_q;
                endcase
            end
            S_SHIFT: begin
                a_d   = {{2{a_q[AW-1]}}, a_q[AW-1:2]};
                q_d   = {a_q[1:0], q_q[W-1:2]};
                qm1_d = q_q[1];
                if (cnt_q == LAST) begin
                    // low 2*WIDTH bits of the shifted {A,Q}
                    prod_d = {a_q[WIDTH-1:0], q_q[W-1:2]};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            mx_q   <= '0;
            q_q    <= '0;
            qm1_q  <= 1'b0;
            cnt_q  <= '0;
            prod_q <= '0;
        end else begin
            a_q    <= a_d;
            mx_q   <= mx_d;
            q_q    <= q_d;
            qm1_q  <= qm1_d;
            cnt_q  <= cnt_d;
            prod_q <= prod_d;
        end
    end

    assign product = prod_q;

endmodule

// File: tb/tb_booth_r4_mult.sv
// Scoreboard bench for booth_r4_mult at WIDTH=8 and WIDTH=16.
module tb_booth_r4_mult;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        s16, sm16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    booth_r4_mult #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .signed_mode(sm8),
        .multiplicand(a8), .multiplier(b8),
        .busy(busy8), .done(done8), .product(p8)
    );

    booth_r4_mult #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .signed_mode(sm16),
        .multiplicand(a16), .multiplier(b16),
        .busy(busy16), .done(done16), .product(p16)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] q8[$];
    int          k8[$];
    logic [31:0] q16[$];
    int          k16[$];
    logic [15:0] last8 = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref8(input bit sm,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        longint ea, eb, pr;
        ea = sm ? longint'($signed(a)) : longint'(a);
        eb = sm ? longint'($signed(b)) : longint'(b);
        pr = ea * eb;
        return pr[15:0];
    endfunction

    function automatic logic [31:0] ref16(input bit sm,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        longint ea, eb, pr;
        ea = sm ? longint'($signed(a)) : longint'(a);
        eb = sm ? longint'($signed(b)) : longint'(b);
        pr = ea * eb;
        return pr[31:0];
    endfunction

    // 8-bit result monitor: product and acceptance-to-done latency
    always @(negedge clk) begin : mon8
        logic [15:0] e;
        int          k;
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                chk("spurious_done8", 32'(q8.size()), 32'd1);
            end else begin
                e = q8.pop_front();
                k = k8.pop_front();
                chk("prod8", 32'(p8), 32'(e));
                chk("lat8", 32'(cyc + 1 - k), 32'd11);
                last8 = e;
            end
        end
    end

    // 16-bit result monitor
    always @(negedge clk) begin : mon16
        logic [31:0] e;
        int          k;
        if (rst_n && done16) begin
            if (q16.size() == 0) begin
                chk("spurious_done16", 32'(q16.size()), 32'd1);
            end else begin
                e = q16.pop_front();
                k = k16.pop_front();
                chk("prod16", p16, e);
                chk("lat16", 32'(cyc + 1 - k), 32'd19);
            end
        end
    end

    // Called at an IDLE negedge; returns at the next IDLE negedge
    task automatic go8(input bit sm, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] e);
        s8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
        q8.push_back(e);
        k8.push_back(cyc + 1);
        @(negedge clk);
        s8 = 1'b0; sm8 = ~sm; a8 = ~a; b8 = 8'($urandom);
        for (int n = 1; n <= 12; n++) begin
            if (n > 1) @(negedge clk);
            chk("busy8", 32'(busy8), 32'(n <= 11));
            chk("done8", 32'(done8), 32'(n == 11));
        end
    endtask

    task automatic go16(input bit sm, input logic [15:0] a,
                        input logic [15:0] b);
        s16 = 1'b1; sm16 = sm; a16 = a; b16 = b;
        q16.push_back(ref16(sm, a, b));
        k16.push_back(cyc + 1);
        @(negedge clk);
        s16 = 1'b0; sm16 = ~sm; a16 = ~a; b16 = 16'($urandom);
        repeat (19) @(negedge clk);
    endtask

    logic [15:0] corner [5];

    initial begin
        corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'h7FFF;
        corner[3] = 16'h8000; corner[4] = 16'hFFFF;
        s8 = 0; sm8 = 0; a8 = '0; b8 = '0;
        s16 = 0; sm16 = 0; a16 = '0; b16 = '0;

        #12;
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_prod8", 32'(p8), 32'd0);
        chk("rst_busy16", 32'(busy16), 32'd0);
        chk("rst_done16", 32'(done16), 32'd0);
        chk("rst_prod16", p16, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        go8(1'b1, 8'h07, 8'hFD, 16'hFFEB);
        go8(1'b1, 8'h80, 8'h80, 16'h4000);
        go8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
        go8(1'b0, 8'h80, 8'h02, 16'h0100);
        go8(1'b1, 8'h80, 8'h02, 16'hFF00);
        go8(1'b1, 8'h00, 8'hA5, 16'h0000);
        go8(1'b0, 8'hC3, 8'h00, 16'h0000);

        // start held high: only edges seen in IDLE accept
        s8 = 1'b1;
        for (int i = 0; i < 36; i++) begin
            sm8 = 1'($urandom);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            if (i % 12 == 0) begin
                q8.push_back(ref8(sm8, a8, b8));
                k8.push_back(cyc + 1);
            end
            chk("stream_done8", 32'(done8), 32'((i % 12) == 11));
            if (i % 12 != 11) chk("hold8", 32'(p8), 32'(last8));
            @(negedge clk);
        end
        s8 = 1'b0;

        // abort in the third SHIFT cycle
        s8 = 1'b1; sm8 = 1'b1; a8 = 8'h55; b8 = 8'h33;
        @(negedge clk);
        s8 = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_abort_busy8", 32'(busy8), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy8", 32'(busy8), 32'd0);
        chk("abort_done8", 32'(done8), 32'd0);
        chk("abort_prod8", 32'(p8), 32'd0);
        last8 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        go8(1'b1, 8'hF9, 8'h03, 16'hFFEB);
        go8(1'b0, 8'h0C, 8'h0B, 16'h0084);

        for (int i = 0; i < 1000; i++) begin
            logic [15:0] a, b;
            a = ($urandom_range(4, 0) == 0) ?
                corner[$urandom_range(4, 0)] : 16'($urandom);
            b = ($urandom_range(4, 0) == 0) ?
                corner[$urandom_range(4, 0)] : 16'($urandom);
            go16(1'($urandom), a, b);
        end

        repeat (3) @(negedge clk);
        chk("drain8", 32'(q8.size()), 32'd0);
        chk("drain16", 32'(q16.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/booth_r4_mult.md
# booth_r4_mult

Parametrised radix-4 Booth sequential multiplier: the complete successor to the fixed-width Booth control unit, with the recoding sequencer and the accumulator/shift datapath in one block. It accepts a WIDTH×WIDTH multiply on a start pulse and selects signed or unsigned operation per request. It iterates two multiplier bits per add/shift pair and returns the 2·WIDTH-bit product with a one-cycle done pulse. It sits as a multi-cycle arithmetic unit behind a simple start/busy/done handshake.

## Interface
- WIDTH, 8: operand width. Must be even and at least 4; other values are a configuration error.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with the operands.
- multiplicand  input  WIDTH  operand M; captured when start is accepted.
- multiplier  input  WIDTH  operand Q; captured when start is accepted.
- busy  output  1  high from the cycle after acceptance through the DONE cycle inclusive.
- done  output  1  one-cycle pulse; product is valid in this cycle.
- product  output  2·WIDTH  result register; holds its value until the next acceptance.

## Operation
- Internal width is W = WIDTH+2. At capture, both operands are sign-extended (signed_mode=1) or zero-extended (signed_mode=0) to W bits. This makes the unsigned case exact with the same recoder.
- Registers:
  - A: W+2 bits, accumulator, cleared on capture.
  - Q: W bits, extended multiplier.
  - q_m1: 1 bit, cleared on capture.
  - Mx: extended multiplicand, sign-extended to W+2 bits.
  - iteration counter: counts 0..I-1, where I = W/2 = WIDTH/2+1.
- FSM states: IDLE, ADD, SHIFT, DONE.
  - IDLE: when start=1, capture the operands, clear A, q_m1 and the counter, and go to ADD. Otherwise stay in IDLE.
  - ADD: recode {Q[1],Q[0],q_m1} and update A. Next state is SHIFT.
    - 000 or 111: A unchanged.
    - 001 or 010: A += Mx.
    - 011: A += 2·Mx.
    - 100: A −= 2·Mx.
    - 101 or 110: A −= Mx.
  - SHIFT: arithmetic right shift of {A,Q,q_m1} by 2, with A's MSB replicated. If counter = I-1, go to DONE; otherwise increment the counter and go to ADD.
  - DONE: product ← low 2·WIDTH bits of {A,Q}. Go to IDLE.
- Arithmetic in A is modulo 2^(W+2). No overflow is possible, because |2·Mx| < 2^(W+1).
- start outside IDLE is ignored. This includes start during DONE. The operand inputs are don't-care outside the accept cycle.
- signed_mode and the operands may change freely while busy; only the captured copies are used.
- Reset mid-operation aborts the multiply. No partial result is ever presented.

## Timing
- Reset values:
  - FSM: IDLE.
  - busy = 0, done = 0, product = 0.
  - A, Q, q_m1 and the counter: 0.
- Acceptance edge k means start=1 sampled in IDLE at edge k.
  - The state is ADD in cycle k+1, and busy=1 from cycle k+1.
  - ADD and SHIFT alternate, one cycle each.
  - DONE is in cycle k+2I+1, with done=1, busy=1 and the product register updated at that point.
  - IDLE is in cycle k+2I+2, with busy=0 and done=0.
- Latency from acceptance edge to the done cycle is 2I+1 cycles: 11 for WIDTH=8, 19 for WIDTH=16.
- The earliest next acceptance is the edge that ends the first IDLE cycle. Back-to-back throughput is one multiply per 2I+2 cycles.
- done is registered, not combinational from the state inputs. busy and done are glitch-free registered outputs or a direct state decode.
- Asynchronous reset asserted in any state: outputs take their reset values immediately. The first acceptance after deassertion is at the first rising edge with rst_n=1 and start=1.

## Test plan
- WIDTH=8, signed, 7 × −3 (0x07, 0xFD) → done in cycle k+11, product = 0xFFEB (−21). busy high in cycles k+1..k+11.
- WIDTH=8, signed, −128 × −128 (0x80, 0x80) → product 0x4000. Then unsigned 255 × 255 (0xFF, 0xFF) → product 0xFE01.
- WIDTH=8, unsigned, 0x80 × 0x02 → 0x0100. Signed, same operands → 0xFF00. Operand 0 in either mode → 0x0000.
- start held high continuously with changing operands → only the IDLE-sampled operands are used. Exactly one done per 2I+2 cycles, and product holds between pulses.
- rst_n pulsed low during the 3rd SHIFT → busy=0, done=0 and product=0 immediately. A new start after release gives the correct result with no stale state.
- WIDTH=16, 1000 random signed/unsigned pairs → product matches the reference model, and done appears exactly 19 cycles after each acceptance.
